// File: rtl/mod_digit_cnt_if.sv
// mod_digit_cnt_if: control and status bundle of one modulo digit counter
interface mod_digit_cnt_if #(parameter int W = 4);
  logic [W-1:0] ival;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic en;
  logic dir;
  logic load;
  logic div_clk;
  logic wrap;
  logic err;
  modport master (output ival, en, dir, load, load_val, input count, div_clk, wrap, err);
  modport slave (input ival, en, dir, load, load_val, output count, div_clk, wrap, err);
endinterface

// File: rtl/mod_digit_cnt.sv
// mod_digit_cnt: modulo-MOD up/down digit counter with load, wrap pulse and toggle-divided clock
module mod_digit_cnt #(
  parameter int MOD = 6,
  parameter int W = 4
) (
  input logic clk10m_i,
  input logic rst_i,
  mod_digit_cnt_if.slave bus
);
  localparam int HALF = MOD / 2;
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] HALF_V = W'(HALF);
  localparam logic [W-1:0] HALF_M1 = W'(HALF - 1);
  if (MOD % 2 != 0 || MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
    $error("mod_digit_cnt: MOD must be even and within 2..2^W");
  end
  logic ival_ok, load_ok, tog, nxt_div, nxt_wrap;
  logic [W-1:0] rst_cnt, ld_cnt, step_cnt, nxt_cnt;
  always_comb begin
    ival_ok = 32'(bus.ival) < MOD;
    load_ok = 32'(bus.load_val) < MOD;
    rst_cnt = ival_ok ? bus.ival : '0;
    ld_cnt = load_ok ? bus.load_val : '0;
    step_cnt = bus.dir ? (bus.count == LAST ? '0 : bus.count + W'(1))
                       : (bus.count == '0 ? LAST : bus.count - W'(1));
    // toggle at the two boundaries crossed by this step instead of decoding count
    tog = bus.dir ? (bus.count == HALF_M1 || bus.count == LAST)
                  : (bus.count == HALF_V || bus.count == '0);
    nxt_cnt = bus.load ? ld_cnt : bus.en ? step_cnt : bus.count;
    nxt_div = bus.load ? (ld_cnt < HALF_V) : bus.en ? bus.div_clk ^ tog : bus.div_clk;
    nxt_wrap = !bus.load && bus.en && (bus.dir ? bus.count == LAST : bus.count == '0);
  end
  always_ff @(posedge clk10m_i or posedge rst_i)
    if (rst_i) begin
      bus.count <= rst_cnt;
      bus.div_clk <= rst_cnt < HALF_V;
      bus.wrap <= 1'b0;
      bus.err <= !ival_ok;
    end else begin
      bus.count <= nxt_cnt;
      bus.div_clk <= nxt_div;
      bus.wrap <= nxt_wrap;
      bus.err <= bus.err | (bus.load && !load_ok);
    end
`ifdef FORMAL
  a_div: assert property (@(posedge clk10m_i) disable iff (rst_i) bus.div_clk == (bus.count < HALF_V));
  a_range: assert property (@(posedge clk10m_i) disable iff (rst_i) 32'(bus.count) < MOD);
  a_wrap: assert property (@(posedge clk10m_i) disable iff (rst_i) !(bus.wrap && $past(bus.wrap) && !bus.en));
`endif
endmodule

// File: tb/tb_mod_digit_cnt.sv
// tb_mod_digit_cnt: checks MOD=6, MOD=10 and MOD=24 counters against a modular-arithmetic model
module tb_mod_digit_cnt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int mods[3] = '{6, 10, 24};
  logic [4:0] ival[3], lval[3];
  logic en[3], dir[3], load[3];
  logic [4:0] cnt[3];
  logic dclk[3], wrp[3], er[3];
  int m_cnt[3];
  bit m_wrap[3], m_err[3];
  mod_digit_cnt_if #(.W(4)) if6 ();
  mod_digit_cnt_if #(.W(4)) if10 ();
  mod_digit_cnt_if #(.W(5)) if24 ();
  mod_digit_cnt #(.MOD(6), .W(4)) u6 (.clk10m_i(clk), .rst_i(rst), .bus(if6));
  mod_digit_cnt #(.MOD(10), .W(4)) u10 (.clk10m_i(clk), .rst_i(rst), .bus(if10));
  mod_digit_cnt #(.MOD(24), .W(5)) u24 (.clk10m_i(clk), .rst_i(rst), .bus(if24));
  assign if6.ival = ival[0][3:0];
  assign if6.load_val = lval[0][3:0];
  assign if6.en = en[0];
  assign if6.dir = dir[0];
  assign if6.load = load[0];
  assign if10.ival = ival[1][3:0];
  assign if10.load_val = lval[1][3:0];
  assign if10.en = en[1];
  assign if10.dir = dir[1];
  assign if10.load = load[1];
  assign if24.ival = ival[2];
  assign if24.load_val = lval[2];
  assign if24.en = en[2];
  assign if24.dir = dir[2];
  assign if24.load = load[2];
  assign cnt[0] = {1'b0, if6.count};
  assign cnt[1] = {1'b0, if10.count};
  assign cnt[2] = if24.count;
  assign dclk = '{if6.div_clk, if10.div_clk, if24.div_clk};
  assign wrp = '{if6.wrap, if10.wrap, if24.wrap};
  assign er = '{if6.err, if10.err, if24.err};
  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[MOD=%0d] observed=%0d expected=%0d", tag, mods[idx], obs, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("count", i, 32'(cnt[i]), 32'(m_cnt[i]));
      chk("div_clk", i, 32'(dclk[i]), 32'(m_cnt[i] < mods[i] / 2));
      chk("wrap", i, 32'(wrp[i]), 32'(m_wrap[i]));
      chk("err", i, 32'(er[i]), 32'(m_err[i]));
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = int'(ival[i]) < mods[i] ? int'(ival[i]) : 0;
      m_wrap[i] = 1'b0;
      m_err[i] = int'(ival[i]) >= mods[i];
    end
  endtask
  task automatic model_edge();
    int raw;
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 1'b0;
      if (load[i]) begin
        m_err[i] |= int'(lval[i]) >= mods[i];
        m_cnt[i] = int'(lval[i]) < mods[i] ? int'(lval[i]) : 0;
      end else if (en[i]) begin
        raw = m_cnt[i] + (dir[i] ? 1 : -1);
        m_cnt[i] = (raw + mods[i]) % mods[i];
        m_wrap[i] = raw != m_cnt[i];
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic set_all(input logic e, input logic d, input logic l);
    for (int i = 0; i < 3; i++) begin
      en[i] = e;
      dir[i] = d;
      load[i] = l;
    end
  endtask
  initial begin
    int n;
    ival = '{5'd0, 5'd0, 5'd0};
    lval = '{5'd0, 5'd0, 5'd0};
    set_all(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
    set_all(1'b1, 1'b1, 1'b0);
    repeat (12) step();
    // reset to an in-range value, then to out-of-range values that must set err
    set_all(1'b0, 1'b1, 1'b0);
    ival = '{5'd4, 5'd4, 5'd4};
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
    #1;
    ival = '{5'd7, 5'd12, 5'd30};
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_all(1'b1, 1'b1, 1'b0);
    repeat (3) step();
    set_all(1'b1, 1'b0, 1'b1);
    lval = '{5'd0, 5'd0, 5'd0};
    step();
    set_all(1'b1, 1'b0, 1'b0);
    step();
    step();
    set_all(1'b0, 1'b0, 1'b0);
    step();
    set_all(1'b0, 1'b1, 1'b1);
    lval = '{5'd5, 5'd9, 5'd23};
    step();
    set_all(1'b1, 1'b1, 1'b1);
    lval = '{5'd2, 5'd2, 5'd2};
    step();
    set_all(1'b0, 1'b1, 1'b1);
    lval = '{5'd6, 5'd10, 5'd24};
    step();
    rst = 1'b1;
    ival = '{5'd1, 5'd3, 5'd11};
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
    set_all(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = 1'($urandom_range(0, 1));
        dir[i] = 1'((k / 7) % 2 == 0);
        load[i] = $urandom_range(0, 15) == 0;
        lval[i] = 5'($urandom_range(0, i == 2 ? 31 : 15));
      end
      step();
    end
    // hit a wrap pulse, then assert reset mid-cycle and expect an immediate reset
    set_all(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!m_wrap[0] && n < 20) begin
      step();
      n++;
    end
    chk("wrap_reached", 0, 32'(wrp[0]), 32'd1);
    ival = '{5'd3, 5'd8, 5'd15};
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
